// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; one-cycle hits and word-by-word
// line refill through a single-outstanding request/done handshake.
module icache #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WORD_BITS  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        clear,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);

  localparam int unsigned Lines = 1 << INDEX_BITS;
  localparam int unsigned Words = 1 << WORD_BITS;
  localparam int unsigned IdxLo = WORD_BITS + 2;
  localparam int unsigned TagLo = IdxLo + INDEX_BITS;
  localparam int unsigned TagW  = 32 - TagLo;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StResp
  } state_e;

  state_e                 r_state;
  logic [WORD_BITS-1:0]   r_cnt;
  logic                   r_cancel;
  logic [31:0]            r_addr;
  logic [Lines-1:0]       r_valid;
  logic [TagW-1:0]        r_tag  [Lines];
  logic [31:0]            r_data [Lines][Words];
  logic                   r_fetch_ready;
  logic [31:0]            r_fetch_inst;

  state_e                 w_state_next;
  logic [WORD_BITS-1:0]   w_cnt_next;
  logic                   w_cancel_next;
  logic [31:0]            w_addr_next;
  logic                   w_ready_next;
  logic [31:0]            w_inst_next;
  logic                   w_fill_we;
  logic                   w_fill_last;
  logic                   w_hit;
  logic                   w_in_fill;

  logic [TagW-1:0]        w_req_tag;
  logic [INDEX_BITS-1:0]  w_req_idx;
  logic [WORD_BITS-1:0]   w_req_word;
  logic [TagW-1:0]        w_lat_tag;
  logic [INDEX_BITS-1:0]  w_lat_idx;
  logic [WORD_BITS-1:0]   w_lat_word;
  logic                   w_unused;

  assign w_req_tag  = fetch_addr[31:TagLo];
  assign w_req_idx  = fetch_addr[TagLo-1:IdxLo];
  assign w_req_word = fetch_addr[IdxLo-1:2];
  assign w_lat_tag  = r_addr[31:TagLo];
  assign w_lat_idx  = r_addr[TagLo-1:IdxLo];
  assign w_lat_word = r_addr[IdxLo-1:2];
  assign w_unused   = ^{fetch_addr[1:0], r_addr[1:0]};

  assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_in_fill = (r_state == StFill);

  assign fetch_ready = r_fetch_ready;
  assign fetch_inst  = r_fetch_inst;
  assign mc_req      = w_in_fill;
  // Line base keeps the latched tag/index, so the word counter never carries out.
  assign mc_addr     = w_in_fill ? {r_addr[31:IdxLo], r_cnt, 2'b00} : 32'h0;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_cancel_next = r_cancel;
    w_addr_next   = r_addr;
    w_ready_next  = 1'b0;
    w_inst_next   = r_fetch_inst;
    w_fill_we     = 1'b0;
    w_fill_last   = 1'b0;
    case (r_state)
      StIdle: begin
        w_cancel_next = 1'b0;
        if (fetch_req && !clear) begin
          if (w_hit) begin
            w_ready_next = 1'b1;
            w_inst_next  = r_data[w_req_idx][w_req_word];
          end else begin
            w_addr_next  = fetch_addr;
            w_cnt_next   = '0;
            w_state_next = StFill;
          end
        end
      end
      StFill: begin
        if (clear) w_cancel_next = 1'b1;
        if (mc_done) begin
          w_fill_we  = 1'b1;
          w_cnt_next = r_cnt + 1'b1;
          if (&r_cnt) begin
            w_fill_last  = 1'b1;
            w_state_next = StResp;
          end
        end
      end
      StResp: begin
        // A flush seen during the fill or in this cycle drops the response.
        if (!(r_cancel || clear)) begin
          w_ready_next = 1'b1;
          w_inst_next  = r_data[w_lat_idx][w_lat_word];
        end
        w_cancel_next = 1'b0;
        w_state_next  = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_cancel      <= 1'b0;
      r_addr        <= 32'h0;
      r_valid       <= '0;
      r_fetch_ready <= 1'b0;
      r_fetch_inst  <= 32'h0;
    end else if (rdy_in) begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cancel      <= w_cancel_next;
      r_addr        <= w_addr_next;
      r_fetch_ready <= w_ready_next;
      r_fetch_inst  <= w_inst_next;
      if (w_fill_last) r_valid[w_lat_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_fill_we) begin
      r_data[w_lat_idx][r_cnt] <= mc_data;
      if (w_fill_last) r_tag[w_lat_idx] <= w_lat_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a hand-stepped memcontroller drives each refill
// and every observed output is compared against hand-computed constants.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        clear;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  int n_cmp = 0;
  int n_err = 0;

  icache #(
    .INDEX_BITS(4),
    .WORD_BITS (2)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .clear      (clear),
    .fetch_ready(fetch_ready),
    .fetch_inst (fetch_inst),
    .mc_req     (mc_req),
    .mc_addr    (mc_addr),
    .mc_done    (mc_done),
    .mc_data    (mc_data)
  );

  always #5 clk_in = ~clk_in;

  // Outputs are observed 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
  endtask

  // Serve words k0..k1 of a refill; each word waits lat cycles before mc_done.
  task automatic fill(input string tag, input logic [31:0] base, input logic [31:0] dbase,
                      input int lat, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      for (int w = 0; w < lat; w++) begin
        chk({tag, " mc_req wait"}, {31'b0, mc_req}, 32'd1);
        chk({tag, " mc_addr wait"}, mc_addr, base + 32'(4 * k));
        chk({tag, " ready in fill"}, {31'b0, fetch_ready}, 32'd0);
        tick();
      end
      chk({tag, " mc_req"}, {31'b0, mc_req}, 32'd1);
      chk({tag, " mc_addr"}, mc_addr, base + 32'(4 * k));
      mc_done = 1'b1;
      mc_data = dbase + 32'(k);
      tick();
      mc_done = 1'b0;
      mc_data = 32'h0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in     = 1'b1;
    rdy_in     = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    clear      = 1'b0;
    mc_done    = 1'b0;
    mc_data    = 32'h0;
    tick();
    tick();
    chk("reset fetch_ready", {31'b0, fetch_ready}, 32'd0);
    chk("reset fetch_inst", fetch_inst, 32'h0);
    chk("reset mc_req", {31'b0, mc_req}, 32'd0);
    chk("reset mc_addr", mc_addr, 32'h0);
    rst_in = 1'b0;

    // Cold miss at 0x104.
    req(32'h104);
    tick();
    fill("cold", 32'h100, 32'hA0, 1, 0, 3);
    chk("cold mc_req low in resp", {31'b0, mc_req}, 32'd0);
    chk("cold no early ready", {31'b0, fetch_ready}, 32'd0);
    tick();
    chk("cold ready", {31'b0, fetch_ready}, 32'd1);
    chk("cold inst", fetch_inst, 32'hA1);
    fetch_req = 1'b0;
    tick();
    chk("cold ready one pulse", {31'b0, fetch_ready}, 32'd0);
    chk("cold mc_req after", {31'b0, mc_req}, 32'd0);

    // Hits, including back-to-back.
    req(32'h10C);
    tick();
    chk("hit 10c ready", {31'b0, fetch_ready}, 32'd1);
    chk("hit 10c inst", fetch_inst, 32'hA3);
    chk("hit 10c no mc_req", {31'b0, mc_req}, 32'd0);
    req(32'h100);
    tick();
    chk("b2b 100 ready", {31'b0, fetch_ready}, 32'd1);
    chk("b2b 100 inst", fetch_inst, 32'hA0);
    req(32'h108);
    tick();
    chk("b2b 108 ready", {31'b0, fetch_ready}, 32'd1);
    chk("b2b 108 inst", fetch_inst, 32'hA2);
    fetch_req = 1'b0;
    tick();
    chk("b2b idle ready", {31'b0, fetch_ready}, 32'd0);

    // Conflict on index 0: 0x200 evicts 0x100, then 0x100 misses again.
    req(32'h200);
    tick();
    fill("conf200", 32'h200, 32'hB0, 0, 0, 3);
    tick();
    chk("conf200 ready", {31'b0, fetch_ready}, 32'd1);
    chk("conf200 inst", fetch_inst, 32'hB0);
    req(32'h100);
    tick();
    chk("conf100 misses", {31'b0, mc_req}, 32'd1);
    fill("conf100", 32'h100, 32'hC0, 2, 0, 3);
    tick();
    chk("conf100 ready", {31'b0, fetch_ready}, 32'd1);
    chk("conf100 inst", fetch_inst, 32'hC0);
    fetch_req = 1'b0;

    // Stray mc_done while idle must not touch the cache.
    mc_done = 1'b1;
    mc_data = 32'h55;
    tick();
    mc_done = 1'b0;
    mc_data = 32'h0;
    chk("stray done mc_req", {31'b0, mc_req}, 32'd0);
    chk("stray done ready", {31'b0, fetch_ready}, 32'd0);
    req(32'h100);
    tick();
    chk("stray done hit ready", {31'b0, fetch_ready}, 32'd1);
    chk("stray done hit inst", fetch_inst, 32'hC0);
    fetch_req = 1'b0;

    // Clear pulsed while the second word of 0x300 is outstanding.
    req(32'h300);
    tick();
    chk("clr mc_addr w0", mc_addr, 32'h300);
    mc_done = 1'b1;
    mc_data = 32'hD0;
    tick();
    mc_done   = 1'b0;
    mc_data   = 32'h0;
    clear     = 1'b1;
    fetch_req = 1'b0;
    tick();
    clear = 1'b0;
    fill("clr", 32'h300, 32'hD0, 0, 1, 3);
    chk("clr mc_req low", {31'b0, mc_req}, 32'd0);
    tick();
    chk("clr no ready", {31'b0, fetch_ready}, 32'd0);
    tick();
    chk("clr no ready later", {31'b0, fetch_ready}, 32'd0);
    req(32'h304);
    tick();
    chk("clr hit 304 ready", {31'b0, fetch_ready}, 32'd1);
    chk("clr hit 304 inst", fetch_inst, 32'hD1);
    chk("clr hit 304 no mc_req", {31'b0, mc_req}, 32'd0);
    fetch_req = 1'b0;

    // rdy_in low for 3 cycles with mc_done high while word 2 is pending.
    req(32'h400);
    tick();
    fill("stall", 32'h400, 32'hE0, 0, 0, 1);
    rdy_in  = 1'b0;
    mc_done = 1'b1;
    mc_data = 32'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall mc_addr frozen", mc_addr, 32'h408);
      chk("stall mc_req frozen", {31'b0, mc_req}, 32'd1);
      chk("stall ready frozen", {31'b0, fetch_ready}, 32'd0);
    end
    rdy_in  = 1'b1;
    mc_done = 1'b0;
    mc_data = 32'h0;
    fill("stall", 32'h400, 32'hE0, 1, 2, 3);
    chk("stall mc_req low", {31'b0, mc_req}, 32'd0);
    tick();
    chk("stall ready", {31'b0, fetch_ready}, 32'd1);
    chk("stall inst", fetch_inst, 32'hE0);
    req(32'h408);
    tick();
    chk("stall hit 408 inst", fetch_inst, 32'hE2);
    fetch_req = 1'b0;

    // Reset after two words of the 0x500 fill.
    req(32'h500);
    tick();
    fill("rstfill", 32'h500, 32'hF0, 0, 0, 1);
    rst_in    = 1'b1;
    fetch_req = 1'b0;
    tick();
    chk("rstfill mc_req dropped", {31'b0, mc_req}, 32'd0);
    chk("rstfill mc_addr", mc_addr, 32'h0);
    rst_in = 1'b0;
    req(32'h500);
    tick();
    chk("rstfill remiss mc_req", {31'b0, mc_req}, 32'd1);
    chk("rstfill remiss word0", mc_addr, 32'h500);
    fill("rstfill2", 32'h500, 32'hF0, 0, 0, 3);
    tick();
    chk("rstfill ready", {31'b0, fetch_ready}, 32'd1);
    chk("rstfill inst", fetch_inst, 32'hF0);
    fetch_req = 1'b0;

    // Top-of-memory line: addresses must not carry out of the line.
    req(32'hFFFF_FFF8);
    tick();
    fill("wrap", 32'hFFFF_FFF0, 32'h90, 0, 0, 3);
    tick();
    chk("wrap ready", {31'b0, fetch_ready}, 32'd1);
    chk("wrap inst", fetch_inst, 32'h92);
    req(32'hFFFF_FFFC);
    tick();
    chk("wrap hit inst", fetch_inst, 32'h93);

    // Clear in IDLE suppresses an otherwise-hitting request.
    req(32'hFFFF_FFF0);
    clear = 1'b1;
    tick();
    chk("idle clear no ready", {31'b0, fetch_ready}, 32'd0);
    chk("idle clear no mc_req", {31'b0, mc_req}, 32'd0);
    clear     = 1'b0;
    fetch_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
